result_display: RTL and testbench
=================================

RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles each digit stays enabled during scanning (minimum 2).
REQ-002 SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 means a segment is lit when driven 0; 0 means lit when driven 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port load, input, 1 bit: capture strobe for setup, co and s.
REQ-006 SHALL have port setup, input, 1 bit: 1 means add result, 0 means subtract result.
REQ-007 SHALL have port s, input, 4 bits: sum or difference from the upstream 4-bit adder/subtractor.
REQ-008 SHALL have port co, input, 1 bit: carry (add mode) or borrow (subtract mode).
REQ-009 SHALL have port busy, output, 1 bit: conversion in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when the displayed value updates.
REQ-011 SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}.
REQ-012 SHALL have port dig, output, 3 bits: active-low digit enables, dig[0]=ones, dig[1]=tens, dig[2]=sign.

Function
REQ-013 SHALL sample load only in IDLE; load asserted while busy=1 SHALL be ignored, with no queuing.
REQ-014 SHALL, on an accepted load, compute a 5-bit magnitude m and a negative flag:
- setup=1: m = {co,s} (0..31), negative = 0.
- setup=0, co=0: m = s (0..15), negative = 0.
- setup=0, co=1: m = 16 - s (1..16), negative = 1.
REQ-015 SHALL implement the FSM IDLE -> CONV -> IDLE.
- IDLE -> CONV on the accepted-load edge; the tens counter clears to 0.
- In CONV, each edge with m >= 10: m <= m - 10, tens <= tens + 1.
- In CONV, an edge with m < 10: commits ones = m, tens and negative to the display registers; returns to IDLE.
REQ-016 SHALL take, for a load accepted at edge k, floor(m/10)+1 CONV cycles.
- busy = 1 from edge k until the commit edge.
- done = 1 for exactly the one cycle after the commit edge.
REQ-017 SHALL update the display registers only at the commit edge, atomically; the display holds the old value while busy.
REQ-018 SHALL decode digits as follows:
- Ones digit: always shows a decimal 0-9.
- Tens digit: blank when tens = 0, else the decimal digit.
- Sign digit: only segment g lit when negative, else blank.
REQ-019 SHALL run the scan counter continuously, independent of the FSM.
- The enabled digit advances 0 -> 1 -> 2 -> 0 every SCAN_DIV cycles.
- Exactly one dig bit is low at any time outside reset.
REQ-020 SHALL drive seg each cycle with the decode of the currently enabled digit, as registered output aligned with dig.
REQ-021 SHALL apply SEG_ACTIVE_LOW polarity to seg only; dig is always active-low.

Reset
REQ-022 SHALL, while rst_n = 0 at a clock edge, set:
- FSM to IDLE, busy = 0, done = 0.
- Display registers to blank on all three digits.
- Scan counter to 0, digit select to ones.
- dig = 3'b111, seg = all segments off.
REQ-023 SHALL, on rst_n = 0 mid-conversion, abandon the conversion with no done pulse; the display stays blank.
REQ-024 SHALL, on the first cycle after reset release, enable dig = 3'b110 with blank seg.

Verification (SEG_ACTIVE_LOW=1, SCAN_DIV=4 unless stated)
REQ-025 SHALL cover reset: rst_n low 3 cycles -> seg = 7'h7F, dig = 3'b111, busy = 0; after release dig = 110, 101, 011 cycling every 4 cycles, seg = 7'h7F throughout.
REQ-026 SHALL cover add 27: setup=1, co=1, s=4'hB, load 1 cycle -> busy high 3 cycles, then done pulses once.
- Ones digit seg = 7'b1111000 ('7').
- Tens digit seg = 7'b0100100 ('2').
- Sign digit seg = 7'h7F.
REQ-027 SHALL cover subtract -3: setup=0, co=1, s=4'hD -> busy 1 cycle, then done.
- Sign digit seg = 7'b0111111.
- Tens digit seg = 7'h7F.
- Ones digit seg = 7'b0110000 ('3').
REQ-028 SHALL cover boundaries:
- setup=0, co=1, s=0 -> display '-','1','6'.
- setup=0, co=0, s=4'h5 -> blank, blank, '5'.
- setup=1, co=0, s=0 -> blank, blank, '0'.
REQ-029 SHALL cover load while busy: load 31, then a second load (value 5) on the next cycle -> second load ignored, display '3','1', exactly one done pulse.
REQ-030 SHALL cover reset mid-operation: load 27, then rst_n low at the second CONV cycle -> no done pulse, display blank, busy = 0 after the reset edge.

Source files
------------

// File: rtl/result_display.sv
// -----------------------------------------------------------------------------
// result_display
//
// Purpose:
//   Captures the result of an upstream 4-bit adder/subtractor (sum/difference
//   plus carry/borrow), converts it to a signed two-digit decimal value by
//   repeated subtraction of ten, and shows it on a three-digit multiplexed
//   7-segment display (sign, tens, ones).
//
// Parameters:
//   SCAN_DIV       - clock cycles each digit stays enabled while scanning (>= 2)
//   SEG_ACTIVE_LOW - 1: a segment is lit when driven 0; 0: lit when driven 1
//
// Ports:
//   clk    in   single clock, rising edge
//   rst_n  in   synchronous active-low reset
//   load   in   capture strobe for setup/co/s (honoured only when idle)
//   setup  in   1 = add result, 0 = subtract result
//   s      in   4-bit sum/difference
//   co     in   carry (add) or borrow (subtract)
//   busy   out  conversion in progress
//   done   out  one-cycle pulse after the displayed value updates
//   seg    out  segments {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   dig    out  active-low digit enables: [0]=ones, [1]=tens, [2]=sign
// -----------------------------------------------------------------------------
module result_display #(
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       setup,
  input  logic [3:0] s,
  input  logic       co,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [2:0] dig
);

  localparam int         CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  // Value driven on seg when no segment is lit.
  localparam logic [6:0] SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  // Active-high pattern for the minus sign: only segment g.
  localparam logic [6:0] SEG_MINUS = 7'b1000000;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [4:0]       mag_q, mag_d;          // remaining magnitude during conversion
  logic [3:0]       tens_q, tens_d;        // tens accumulated during conversion
  logic             neg_q, neg_d;          // sign captured at load
  logic             done_q, done_d;

  // Display registers: written only at the commit edge, all together.
  logic             disp_valid_q, disp_valid_d;  // 0 = everything blank
  logic [3:0]       disp_ones_q, disp_ones_d;
  logic [3:0]       disp_tens_q, disp_tens_d;
  logic             disp_neg_q, disp_neg_d;

  // Scanning
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       sel_q, sel_d;          // 0 = ones, 1 = tens, 2 = sign
  logic [6:0]       seg_q, seg_d;
  logic [2:0]       dig_q, dig_d;

  // ---------------------------------------------------------------------------
  // Load-time magnitude/sign. A borrow in subtract mode means the true result
  // is s - 16, so its magnitude is 16 - s.
  // ---------------------------------------------------------------------------
  logic [4:0] load_mag;
  logic       load_neg;

  always_comb begin
    load_mag = {co, s};
    load_neg = 1'b0;
    if (!setup) begin
      if (co) begin
        load_mag = 5'd16 - {1'b0, s};
        load_neg = 1'b1;
      end else begin
        load_mag = {1'b0, s};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Conversion FSM: one ten is peeled off per CONV cycle; the cycle that finds
  // fewer than ten remaining commits the digits and returns to IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    mag_d        = mag_q;
    tens_d       = tens_q;
    neg_d        = neg_q;
    done_d       = 1'b0;
    disp_valid_d = disp_valid_q;
    disp_ones_d  = disp_ones_q;
    disp_tens_d  = disp_tens_q;
    disp_neg_d   = disp_neg_q;

    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = CONV;
          mag_d   = load_mag;
          neg_d   = load_neg;
          tens_d  = 4'd0;
        end
      end
      CONV: begin
        if (mag_q >= 5'd10) begin
          mag_d  = mag_q - 5'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          disp_valid_d = 1'b1;
          disp_ones_d  = mag_q[3:0];
          disp_tens_d  = tens_q;
          disp_neg_d   = neg_q;
          done_d       = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Decimal digit to active-high segment pattern {g,f,e,d,c,b,a}.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'd0:    dec7 = 7'b0111111;
      4'd1:    dec7 = 7'b0000110;
      4'd2:    dec7 = 7'b1011011;
      4'd3:    dec7 = 7'b1001111;
      4'd4:    dec7 = 7'b1100110;
      4'd5:    dec7 = 7'b1101101;
      4'd6:    dec7 = 7'b1111101;
      4'd7:    dec7 = 7'b0000111;
      4'd8:    dec7 = 7'b1111111;
      4'd9:    dec7 = 7'b1101111;
      default: dec7 = 7'b0000000;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Scan: free-running, independent of the FSM. seg/dig are registered from
  // the same sel_q so they always change together.
  // ---------------------------------------------------------------------------
  logic [2:0] dig_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dig
      assign dig_sel[gi] = (sel_q != 2'(gi));
    end
  endgenerate

  logic [6:0] lit;

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    sel_d      = sel_q;
    if (scan_cnt_q == CNT_LAST) begin
      scan_cnt_d = '0;
      sel_d      = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
    end

    lit = 7'b0000000;
    case (sel_q)
      2'd0:    lit = disp_valid_q ? dec7(disp_ones_q) : 7'b0000000;
      2'd1:    lit = (disp_valid_q && disp_tens_q != 4'd0) ? dec7(disp_tens_q) : 7'b0000000;
      default: lit = (disp_valid_q && disp_neg_q) ? SEG_MINUS : 7'b0000000;
    endcase

    seg_d = (SEG_ACTIVE_LOW != 0) ? ~lit : lit;
    dig_d = dig_sel;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mag_q        <= '0;
      tens_q       <= '0;
      neg_q        <= 1'b0;
      done_q       <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_ones_q  <= '0;
      disp_tens_q  <= '0;
      disp_neg_q   <= 1'b0;
      scan_cnt_q   <= '0;
      sel_q        <= 2'd0;
      seg_q        <= SEG_OFF;
      dig_q        <= 3'b111;
    end else begin
      state_q      <= state_d;
      mag_q        <= mag_d;
      tens_q       <= tens_d;
      neg_q        <= neg_d;
      done_q       <= done_d;
      disp_valid_q <= disp_valid_d;
      disp_ones_q  <= disp_ones_d;
      disp_tens_q  <= disp_tens_d;
      disp_neg_q   <= disp_neg_d;
      scan_cnt_q   <= scan_cnt_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
    end
  end

  assign busy = (state_q == CONV);
  assign done = done_q;
  assign seg  = seg_q;
  assign dig  = dig_q;

endmodule

// File: tb/tb_result_display.sv
// -----------------------------------------------------------------------------
// tb_result_display
//
// Directed bench for result_display with SCAN_DIV=4, SEG_ACTIVE_LOW=1.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_result_display;

  localparam logic [6:0] S_OFF = 7'h7F;
  localparam logic [6:0] S_MIN = 7'b0111111;
  localparam logic [6:0] S_0   = 7'b1000000;
  localparam logic [6:0] S_1   = 7'b1111001;
  localparam logic [6:0] S_2   = 7'b0100100;
  localparam logic [6:0] S_3   = 7'b0110000;
  localparam logic [6:0] S_5   = 7'b0010010;
  localparam logic [6:0] S_6   = 7'b0000010;
  localparam logic [6:0] S_7   = 7'b1111000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       load  = 1'b0;
  logic       setup = 1'b0;
  logic [3:0] s     = 4'd0;
  logic       co    = 1'b0;
  logic       busy;
  logic       done;
  logic [6:0] seg;
  logic [2:0] dig;

  int checks = 0;
  int errors = 0;

  logic [6:0] rd_sign, rd_tens, rd_ones;
  logic       rd_ok;

  result_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .setup (setup),
    .s     (s),
    .co    (co),
    .busy  (busy),
    .done  (done),
    .seg   (seg),
    .dig   (dig)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Watch the scan for up to 16 cycles and grab the pattern of each digit.
  task automatic read_display();
    logic got_s, got_t, got_o;
    got_s = 1'b0; got_t = 1'b0; got_o = 1'b0;
    rd_sign = 'x; rd_tens = 'x; rd_ones = 'x;
    for (int i = 0; i < 16 && !(got_s && got_t && got_o); i++) begin
      @(negedge clk);
      case (dig)
        3'b110: begin rd_ones = seg; got_o = 1'b1; end
        3'b101: begin rd_tens = seg; got_t = 1'b1; end
        3'b011: begin rd_sign = seg; got_s = 1'b1; end
        default: ;
      endcase
    end
    rd_ok = got_s && got_t && got_o;
  endtask

  task automatic check_display(input string tag, input logic [6:0] e_sign,
                               input logic [6:0] e_tens, input logic [6:0] e_ones);
    read_display();
    check({tag, "_scan_ok"}, 8'(rd_ok), 8'd1);
    check({tag, "_sign"}, 8'(rd_sign), 8'(e_sign));
    check({tag, "_tens"}, 8'(rd_tens), 8'(e_tens));
    check({tag, "_ones"}, 8'(rd_ones), 8'(e_ones));
    $display("display %s: sign=%h tens=%h ones=%h", tag, rd_sign, rd_tens, rd_ones);
  endtask

  // Issue one load, measure busy length, verify a single done pulse.
  task automatic do_load(input string tag, input logic su, input logic c,
                         input logic [3:0] v, input int exp_busy);
    int n;
    int early_done;
    setup = su; co = c; s = v; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    early_done = 0;
    while (busy === 1'b1 && n < 40) begin
      if (done === 1'b1) early_done++;
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 8'(n), 8'(exp_busy));
    check({tag, "_done_during_busy"}, 8'(early_done), 8'd0);
    check({tag, "_done_pulse"}, 8'(done), 8'd1);
    @(negedge clk);
    check({tag, "_done_clear"}, 8'(done), 8'd0);
    $display("load %s: setup=%0b co=%0b s=%h busy_cycles=%0d", tag, su, c, v, n);
  endtask

  initial begin
    int dcount;
    logic [2:0] exp_dig;

    // ---------------- Reset ----------------
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_seg", 8'(seg), 8'(S_OFF));
      check("rst_dig", 8'(dig), 8'(3'b111));
      check("rst_busy", 8'(busy), 8'd0);
      check("rst_done", 8'(done), 8'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp_dig = (i < 4) ? 3'b110 : (i < 8) ? 3'b101 : 3'b011;
      check("scan_dig", 8'(dig), 8'(exp_dig));
      check("scan_seg_blank", 8'(seg), 8'(S_OFF));
    end
    $display("reset: scan sequence observed after release");

    // ---------------- Add 27 ----------------
    do_load("add27", 1'b1, 1'b1, 4'hB, 3);
    check_display("add27", S_OFF, S_2, S_7);

    // ---------------- Subtract -3 ----------------
    do_load("sub_m3", 1'b0, 1'b1, 4'hD, 1);
    check_display("sub_m3", S_MIN, S_OFF, S_3);

    // ---------------- Boundaries ----------------
    do_load("sub_m16", 1'b0, 1'b1, 4'h0, 2);
    check_display("sub_m16", S_MIN, S_1, S_6);

    do_load("sub_p5", 1'b0, 1'b0, 4'h5, 1);
    check_display("sub_p5", S_OFF, S_OFF, S_5);

    do_load("add0", 1'b1, 1'b0, 4'h0, 1);
    check_display("add0", S_OFF, S_OFF, S_0);

    // ---------------- Load while busy ----------------
    setup = 1'b1; co = 1'b1; s = 4'hF; load = 1'b1;
    @(negedge clk);
    check("lwb_busy_first", 8'(busy), 8'd1);
    setup = 1'b1; co = 1'b0; s = 4'h5; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) dcount++;
      @(negedge clk);
    end
    check("lwb_done_count", 8'(dcount), 8'd1);
    check("lwb_busy_end", 8'(busy), 8'd0);
    $display("load while busy: done pulses=%0d", dcount);
    check_display("lwb31", S_OFF, S_3, S_1);

    // ---------------- Reset mid-operation ----------------
    setup = 1'b1; co = 1'b1; s = 4'hB; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("rmid_busy_conv1", 8'(busy), 8'd1);
    @(negedge clk);
    check("rmid_busy_conv2", 8'(busy), 8'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rmid_busy_after_rst", 8'(busy), 8'd0);
    check("rmid_done_after_rst", 8'(done), 8'd0);
    check("rmid_dig_after_rst", 8'(dig), 8'(3'b111));
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    check("rmid_no_done", 8'(dcount), 8'd0);
    $display("reset mid-operation: done pulses after reset=%0d", dcount);
    check_display("rmid", S_OFF, S_OFF, S_OFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
